// File: rtl/lsu.sv
// Load/store unit: turns ALU results into byte/half/word accesses on a req/ack
// data bus, stalling the core until the access retires.
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_r, state_s;
  logic [1:0]    off_r;
  logic [2:0]    f3_r;
  logic [CW-1:0] cnt_r;
  logic          mem_req_r, mem_we_r;
  logic [31:0]   mem_addr_r, mem_wdata_r;
  logic [3:0]    mem_be_r;
  logic          done_r, misalign_r, buserr_r;
  logic [31:0]   rdata_r;
  logic          req_s, illegal_s, tmo_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;

  // Select the addressed lane of a bus word and extend it per load type.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b010:  fmt_load = w;
      3'b100:  fmt_load = {24'h000000, b};
      3'b101:  fmt_load = {16'h0000, h};
      default: fmt_load = 32'h0000_0000;
    endcase
  endfunction

  assign req_s = MemRead | MemWrite;
  assign tmo_s = (TIMEOUT != 0) && (cnt_r == TMO_LAST);

  // Decode legality, byte enables and lane-replicated store data for the request.
  always_comb begin
    illegal_s = 1'b0;
    be_s      = 4'b0000;
    wdata_s   = 32'h0000_0000;
    if (MemRead && MemWrite) begin
      illegal_s = 1'b1;
    end else begin
      case (Funct3)
        3'b000: begin
          be_s    = 4'b0001 << ALUResult[1:0];
          wdata_s = MemWrite ? {4{WriteData[7:0]}} : 32'h0000_0000;
        end
        3'b001: begin
          be_s      = ALUResult[1] ? 4'b1100 : 4'b0011;
          wdata_s   = MemWrite ? {2{WriteData[15:0]}} : 32'h0000_0000;
          illegal_s = ALUResult[0];
        end
        3'b010: begin
          be_s      = 4'b1111;
          wdata_s   = MemWrite ? WriteData : 32'h0000_0000;
          illegal_s = |ALUResult[1:0];
        end
        3'b100: begin
          be_s      = 4'b0001 << ALUResult[1:0];
          illegal_s = MemWrite;
        end
        3'b101: begin
          be_s      = ALUResult[1] ? 4'b1100 : 4'b0011;
          illegal_s = MemWrite | ALUResult[0];
        end
        default: illegal_s = 1'b1;
      endcase
    end
  end

  // Next-state logic; an ack in the same cycle as the timeout wins.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_s) state_s = illegal_s ? S_DONE : S_BUSY;
        else       state_s = S_IDLE;
      end
      S_BUSY: begin
        if (mem_ack || tmo_s) state_s = S_DONE;
        else                  state_s = S_BUSY;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, latched bus request and registered retire outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      off_r       <= 2'd0;
      f3_r        <= 3'd0;
      cnt_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      done_r      <= 1'b0;
      misalign_r  <= 1'b0;
      buserr_r    <= 1'b0;
      rdata_r     <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      buserr_r   <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      case (state_r)
        S_IDLE: begin
          if (req_s) begin
            off_r       <= ALUResult[1:0];
            f3_r        <= Funct3;
            cnt_r       <= '0;
            mem_we_r    <= MemWrite;
            mem_addr_r  <= {ALUResult[31:2], 2'b00};
            mem_be_r    <= be_s;
            mem_wdata_r <= wdata_s;
            mem_req_r   <= ~illegal_s;
            done_r      <= illegal_s;
            misalign_r  <= illegal_s;
          end else begin
            mem_req_r <= 1'b0;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            done_r    <= 1'b1;
            rdata_r   <= mem_we_r ? 32'h0000_0000 : fmt_load(f3_r, off_r, mem_rdata);
          end else if (tmo_s) begin
            mem_req_r <= 1'b0;
            done_r    <= 1'b1;
            buserr_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_DONE:  mem_req_r <= 1'b0;
        default: mem_req_r <= 1'b0;
      endcase
    end
  end

  assign Stall       = (state_r == S_BUSY) || ((state_r == S_IDLE) && req_s);
  assign Done        = done_r;
  assign MisalignErr = misalign_r;
  assign BusErr      = buserr_r;
  assign ReadData    = rdata_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_be      = mem_be_r;
  assign mem_wdata   = mem_wdata_r;

endmodule
